// File: rtl/register_bank.sv
// rtl/register_bank.sv - MIPS 32x32 register bank with registered reads and clear sweep
//
// Purpose: general-purpose register file for the multicycle datapath. Two
// registered read ports (rs/rt), one write port, and a 31-cycle clear sweep
// that re-initialises registers 1..31 without a global reset.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   reg_write    write enable (accepted only while idle)
//   read_reg_a   read port A address (rs)
//   read_reg_b   read port B address (rt)
//   write_reg    write address
//   write_data   write data
//   clear_req    starts a clear sweep when idle
//   read_data_a  registered contents of read_reg_a
//   read_data_b  registered contents of read_reg_b
//   busy         clear sweep in progress
//
// Configuration macro: REGISTER_BANK_BYPASS_EN
//   defined     - a read port addressing the register being written this
//                 edge captures write_data (write-before-read)
//   not defined - read ports capture the pre-write contents

module register_bank #(
  parameter int          DATA_WIDTH = 32,
  parameter int          SP_INDEX   = 29,
  parameter int unsigned SP_RESET   = 227
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reg_write,
  input  logic [4:0]            read_reg_a,
  input  logic [4:0]            read_reg_b,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] SP_RESET_W = DATA_WIDTH'(SP_RESET);
  localparam logic [4:0]            SP_IDX_W   = 5'(SP_INDEX);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t                r_state;
  logic [4:0]            r_idx;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_regs [0:31];
  logic [DATA_WIDTH-1:0] r_read_a;
  logic [DATA_WIDTH-1:0] r_read_b;

  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_next_a;
  logic [DATA_WIDTH-1:0] w_next_b;

  // Writes are only honoured while idle; during a sweep they are dropped.
  assign w_wr_en = (r_state == S_IDLE) && reg_write && (write_reg != 5'd0);

  // Index 0 is forced to zero at the read mux, so r_regs[0] is never relied on.
  always_comb begin
    w_next_a = (read_reg_a == 5'd0) ? '0 : r_regs[read_reg_a];
    w_next_b = (read_reg_b == 5'd0) ? '0 : r_regs[read_reg_b];
`ifdef REGISTER_BANK_BYPASS_EN
    // w_wr_en already excludes write_reg == 0 and the sweep state.
    if (w_wr_en && (read_reg_a == write_reg)) w_next_a = write_data;
    if (w_wr_en && (read_reg_b == write_reg)) w_next_b = write_data;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == SP_INDEX) ? SP_RESET_W : '0;
      end
      r_read_a <= '0;
      r_read_b <= '0;
      r_state  <= S_IDLE;
      r_idx    <= 5'd1;
      r_busy   <= 1'b0;
    end else begin
      r_read_a <= w_next_a;
      r_read_b <= w_next_b;
      case (r_state)
        S_IDLE: begin
          if (w_wr_en) r_regs[write_reg] <= write_data;
          if (clear_req) begin
            r_state <= S_SWEEP;
            r_idx   <= 5'd1;
            r_busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          r_regs[r_idx] <= (r_idx == SP_IDX_W) ? SP_RESET_W : '0;
          if (r_idx == 5'd31) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd1;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= 5'd1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign read_data_a = r_read_a;
  assign read_data_b = r_read_b;
  assign busy        = r_busy;

endmodule
